// File: rtl/usb3_lfps_rx_classifier.sv
// LFPS receive engine: synchronises and deglitches the PIPE idle/valid pair, measures
// burst width and start-to-start period, and classifies each burst against the link power state.
//
// state    | meaning
// IDLE     | waiting for a filtered rise
// BURST    | filtered LFPS high, len counting
// CLASSIFY | one cycle after the filtered fall, emits the single result pulse
module usb3_lfps_rx_classifier #(
  parameter int CW          = 25,
  parameter int FILTER_LEN  = 2,
  parameter int POLL_MIN    = 38,
  parameter int POLL_MAX    = 88,
  parameter int REP_MIN     = 375,
  parameter int REP_MAX     = 875,
  parameter int POLL_REPEAT = 2,
  parameter int PING_MIN    = 3,
  parameter int PING_MAX    = 13,
  parameter int U1_MAX      = 125000,
  parameter int U2_MIN      = 5000,
  parameter int U2_MAX      = 125000,
  parameter int U3_MAX      = 625000,
  parameter int RESET_DELAY = 1125000,
  parameter int RESET_MIN   = 5000000,
  parameter int RESET_MAX   = 7500000
) (
  input  logic          slow_clk,
  input  logic          reset_n,
  input  logic          i_enable,
  input  logic          i_port_rx_elecidle,
  input  logic          i_port_rx_valid,
  input  logic [1:0]    i_link_ps,
  output logic          o_lfps_active,
  output logic          o_recv_poll_u1,
  output logic          o_recv_ping,
  output logic          o_recv_u2lb,
  output logic          o_recv_u3,
  output logic          o_recv_reset,
  output logic          o_reset_detect,
  output logic          o_recv_invalid,
  output logic [CW-1:0] o_burst_len,
  output logic [3:0]    o_poll_run
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_CLASSIFY} state_t;

  localparam logic [CW-1:0] L_POLL_MIN    = CW'(POLL_MIN);
  localparam logic [CW-1:0] L_POLL_MAX    = CW'(POLL_MAX);
  localparam logic [CW-1:0] L_REP_MIN     = CW'(REP_MIN);
  localparam logic [CW-1:0] L_REP_MAX     = CW'(REP_MAX);
  localparam logic [CW-1:0] L_PING_MIN    = CW'(PING_MIN);
  localparam logic [CW-1:0] L_PING_MAX    = CW'(PING_MAX);
  localparam logic [CW-1:0] L_U1_MAX      = CW'(U1_MAX);
  localparam logic [CW-1:0] L_U2_MIN      = CW'(U2_MIN);
  localparam logic [CW-1:0] L_U2_MAX      = CW'(U2_MAX);
  localparam logic [CW-1:0] L_U3_MAX      = CW'(U3_MAX);
  localparam logic [CW-1:0] L_RESET_DELAY = CW'(RESET_DELAY);
  localparam logic [CW-1:0] L_RESET_MIN   = CW'(RESET_MIN);
  localparam logic [CW-1:0] L_RESET_MAX   = CW'(RESET_MAX);
  localparam logic [3:0]    L_FILT_LAST   = 4'(FILTER_LEN - 1);
  localparam logic [3:0]    L_POLL_REP    = 4'(POLL_REPEAT);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic in_win(input logic [CW-1:0] v, input logic [CW-1:0] lo,
                                  input logic [CW-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic          r_eidle_s1, r_eidle_s2, r_valid_s1, r_valid_s2;
  logic          r_filt;
  logic [3:0]    r_fcnt;
  logic [CW-1:0] r_len, r_per, r_last_period;
  logic          r_rise_pend, r_rep_ok, r_last_poll;
  logic [3:0]    r_poll_run;
  logic [CW-1:0] r_burst_len;
  state_t        r_state, w_state_nxt;

  logic          w_raw, w_flip, w_rise, w_start;
  logic [CW-1:0] w_period;
  logic          w_ping, w_poll, w_u1, w_u2, w_u3, w_rst, w_poll_ok;
  logic [3:0]    w_poll_next;

  // Elecidle synchroniser resets to "idle" so reset release cannot fake an LFPS edge.
  always_ff @(posedge slow_clk) begin
    if (!reset_n) begin
      r_eidle_s1 <= 1'b1;
      r_eidle_s2 <= 1'b1;
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
    end else begin
      r_eidle_s1 <= i_port_rx_elecidle;
      r_eidle_s2 <= r_eidle_s1;
      r_valid_s1 <= i_port_rx_valid;
      r_valid_s2 <= r_valid_s1;
    end
  end

  assign w_raw  = ~r_eidle_s2 & ~r_valid_s2;
  assign w_flip = (w_raw != r_filt) && (r_fcnt == L_FILT_LAST);
  assign w_rise = w_flip & w_raw;

  always_ff @(posedge slow_clk) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_fcnt <= 4'd0;
    end else if (w_raw == r_filt) begin
      r_fcnt <= 4'd0;
    end else if (w_flip) begin
      r_filt <= w_raw;
      r_fcnt <= 4'd0;
    end else begin
      r_fcnt <= r_fcnt + 4'd1;
    end
  end

  // Period is latched on every rise so a rise landing in CLASSIFY still has its period.
  always_ff @(posedge slow_clk) begin
    if (!reset_n || !i_enable) begin
      r_len         <= '0;
      r_per         <= '0;
      r_last_period <= '0;
    end else if (w_rise) begin
      r_len         <= '0;
      r_per         <= '0;
      r_last_period <= sat_inc(r_per);
    end else begin
      if (r_filt) r_len <= sat_inc(r_len);
      r_per <= sat_inc(r_per);
    end
  end

  assign w_period = w_rise ? sat_inc(r_per) : r_last_period;
  assign w_start  = w_rise || (r_filt && r_rise_pend);

  always_ff @(posedge slow_clk) begin
    if (!reset_n || !i_enable) r_state <= S_IDLE;
    else                       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_state_nxt = S_BURST;
      S_BURST:    if (!r_filt) w_state_nxt = S_CLASSIFY;
      S_CLASSIFY: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ping      = in_win(r_len, L_PING_MIN, L_PING_MAX);
  assign w_poll      = (i_link_ps == 2'd0) && in_win(r_len, L_POLL_MIN, L_POLL_MAX);
  assign w_u1        = (i_link_ps == 2'd1) && in_win(r_len, L_POLL_MIN, L_U1_MAX);
  assign w_u2        = (i_link_ps == 2'd2) && in_win(r_len, L_U2_MIN, L_U2_MAX);
  assign w_u3        = (i_link_ps == 2'd3) && in_win(r_len, L_U2_MIN, L_U3_MAX);
  assign w_rst       = in_win(r_len, L_RESET_MIN, L_RESET_MAX);
  assign w_poll_next = r_rep_ok ? ((r_poll_run == 4'hF) ? 4'hF : r_poll_run + 4'd1) : 4'd1;
  assign w_poll_ok   = (w_poll_next >= L_POLL_REP);

  always_comb begin
    o_recv_ping    = 1'b0;
    o_recv_poll_u1 = 1'b0;
    o_recv_u2lb    = 1'b0;
    o_recv_u3      = 1'b0;
    o_recv_reset   = 1'b0;
    o_recv_invalid = 1'b0;
    o_reset_detect = (r_state == S_BURST) && r_filt && (r_len >= L_RESET_DELAY);
    if (r_state == S_CLASSIFY) begin
      if (w_ping)      o_recv_ping    = 1'b1;
      else if (w_poll) o_recv_poll_u1 = w_poll_ok;
      else if (w_u1)   o_recv_poll_u1 = 1'b1;
      else if (w_u2)   o_recv_u2lb    = 1'b1;
      else if (w_u3)   o_recv_u3      = 1'b1;
      else if (w_rst)  o_recv_reset   = 1'b1;
      else             o_recv_invalid = 1'b1;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (!reset_n) begin
      r_burst_len <= '0;
    end else if (i_enable && r_state == S_CLASSIFY) begin
      r_burst_len <= r_len;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (!reset_n || !i_enable) begin
      r_rise_pend <= 1'b0;
      r_rep_ok    <= 1'b0;
      r_last_poll <= 1'b0;
      r_poll_run  <= 4'd0;
    end else begin
      if (r_state == S_CLASSIFY && w_rise) r_rise_pend <= 1'b1;
      else if (r_state == S_IDLE)          r_rise_pend <= 1'b0;
      if (r_state == S_IDLE && w_start)
        r_rep_ok <= r_last_poll && in_win(w_period, L_REP_MIN, L_REP_MAX);
      if (r_state == S_CLASSIFY) begin
        if (!w_ping && w_poll) begin
          r_poll_run  <= w_poll_next;
          r_last_poll <= 1'b1;
        end else begin
          r_poll_run  <= 4'd0;
          r_last_poll <= 1'b0;
        end
      end
    end
  end

  assign o_lfps_active = r_filt;
  assign o_burst_len   = r_burst_len;
  assign o_poll_run    = r_poll_run;

endmodule

// File: tb/tb_usb3_lfps_rx_classifier.sv
// Directed bench for usb3_lfps_rx_classifier with the long-burst windows scaled down
// so WarmReset and U2/U3 bursts fit a short run.
module tb_usb3_lfps_rx_classifier;

  localparam int CW = 25;

  logic          slow_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_enable = 1'b1;
  logic          i_port_rx_elecidle = 1'b1;
  logic          i_port_rx_valid = 1'b0;
  logic [1:0]    i_link_ps = 2'd0;
  logic          o_lfps_active, o_recv_poll_u1, o_recv_ping, o_recv_u2lb, o_recv_u3;
  logic          o_recv_reset, o_reset_detect, o_recv_invalid;
  logic [CW-1:0] o_burst_len;
  logic [3:0]    o_poll_run;

  usb3_lfps_rx_classifier #(
    .CW(CW), .FILTER_LEN(2),
    .U1_MAX(250), .U2_MIN(100), .U2_MAX(250), .U3_MAX(1250),
    .RESET_DELAY(2250), .RESET_MIN(10000), .RESET_MAX(15000)
  ) dut (
    .slow_clk(slow_clk), .reset_n(reset_n), .i_enable(i_enable),
    .i_port_rx_elecidle(i_port_rx_elecidle), .i_port_rx_valid(i_port_rx_valid),
    .i_link_ps(i_link_ps), .o_lfps_active(o_lfps_active),
    .o_recv_poll_u1(o_recv_poll_u1), .o_recv_ping(o_recv_ping),
    .o_recv_u2lb(o_recv_u2lb), .o_recv_u3(o_recv_u3), .o_recv_reset(o_recv_reset),
    .o_reset_detect(o_reset_detect), .o_recv_invalid(o_recv_invalid),
    .o_burst_len(o_burst_len), .o_poll_run(o_poll_run)
  );

  always #5 slow_clk = ~slow_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc, fall_cyc;
  int last_pulse_cyc = 0, act_rise_cyc = 0, rd_rise_cyc = 0, rd_last_cyc = 0, n_rd_rise = 0;
  int n_p[6];
  int s_p[6];
  logic rd_prev = 1'b0, act_prev = 1'b0;

  always @(posedge slow_clk) cyc <= cyc + 1;

  // Pulse order: poll_u1, ping, u2lb, u3, reset, invalid
  always @(negedge slow_clk) begin
    if (o_recv_poll_u1) n_p[0] <= n_p[0] + 1;
    if (o_recv_ping)    n_p[1] <= n_p[1] + 1;
    if (o_recv_u2lb)    n_p[2] <= n_p[2] + 1;
    if (o_recv_u3)      n_p[3] <= n_p[3] + 1;
    if (o_recv_reset)   n_p[4] <= n_p[4] + 1;
    if (o_recv_invalid) n_p[5] <= n_p[5] + 1;
    if (o_recv_poll_u1 | o_recv_ping | o_recv_u2lb | o_recv_u3 | o_recv_reset | o_recv_invalid)
      last_pulse_cyc <= cyc;
    rd_prev  <= o_reset_detect;
    act_prev <= o_lfps_active;
    if (o_reset_detect && !rd_prev) begin
      n_rd_rise   <= n_rd_rise + 1;
      rd_rise_cyc <= cyc;
    end
    if (o_reset_detect) rd_last_cyc <= cyc;
    if (o_lfps_active && !act_prev) act_rise_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic [23:0] exp);
    logic [23:0] d;
    d = '0;
    for (int i = 0; i < 6; i++) d[23-4*i -: 4] = 4'(n_p[i] - s_p[i]);
    check(tag, {40'd0, d}, {40'd0, exp});
    for (int i = 0; i < 6; i++) s_p[i] = n_p[i];
  endtask

  task automatic drive_raw(input bit v);
    i_port_rx_elecidle = ~v;
    i_port_rx_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge slow_clk);
    #1;
  endtask

  // Raw LFPS high for n cycles; returns period cycles after the start.
  task automatic burst(input int n, input int period);
    @(posedge slow_clk); #1;
    drive_raw(1'b1);
    rise_cyc = cyc;
    repeat (n) @(posedge slow_clk);
    #1;
    drive_raw(1'b0);
    fall_cyc = cyc;
    repeat (period - n - 1) @(posedge slow_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin n_p[i] = 0; s_p[i] = 0; end
    idle(5);
    check("rst_active", {63'd0, o_lfps_active}, 64'd0);
    check("rst_poll_run", {60'd0, o_poll_run}, 64'd0);
    check("rst_burst_len", {39'd0, o_burst_len}, 64'd0);
    check("rst_reset_det", {63'd0, o_reset_detect}, 64'd0);
    reset_n = 1'b1;
    idle(20);
    chk_pulses("rst_pulses", 24'h000000);

    // Polling train at 600-cycle period
    burst(60, 600);
    check("act_latency", act_rise_cyc - rise_cyc, 64'd4);
    check("pA1_run", {60'd0, o_poll_run}, 64'd1);
    check("pA1_len", {39'd0, o_burst_len}, 64'd60);
    chk_pulses("pA1_pulse", 24'h000000);
    burst(60, 600);
    check("pA2_run", {60'd0, o_poll_run}, 64'd2);
    chk_pulses("pA2_pulse", 24'h100000);
    check("pA2_lat", last_pulse_cyc - fall_cyc, 64'd5);
    burst(60, 600);
    check("pA3_run", {60'd0, o_poll_run}, 64'd3);
    chk_pulses("pA3_pulse", 24'h100000);
    check("pA3_lat", last_pulse_cyc - fall_cyc, 64'd5);
    idle(1000);

    // Polling train with an out-of-window second period
    burst(60, 1000);
    check("pB1_run", {60'd0, o_poll_run}, 64'd1);
    chk_pulses("pB1_pulse", 24'h000000);
    burst(60, 600);
    check("pB2_run", {60'd0, o_poll_run}, 64'd1);
    chk_pulses("pB2_pulse", 24'h000000);
    burst(60, 600);
    check("pB3_run", {60'd0, o_poll_run}, 64'd2);
    chk_pulses("pB3_pulse", 24'h100000);

    // Ping, short invalid, glitch
    burst(5, 40);
    chk_pulses("ping_pulse", 24'h010000);
    check("ping_len", {39'd0, o_burst_len}, 64'd5);
    check("ping_run", {60'd0, o_poll_run}, 64'd0);
    burst(2, 40);
    chk_pulses("short_pulse", 24'h000001);
    check("short_len", {39'd0, o_burst_len}, 64'd2);
    burst(1, 40);
    chk_pulses("glitch_pulse", 24'h000000);
    check("glitch_len", {39'd0, o_burst_len}, 64'd2);

    // Same 200-cycle burst under each link power state
    i_link_ps = 2'd1; burst(200, 240);
    chk_pulses("u1_pulse", 24'h100000);
    check("u1_len", {39'd0, o_burst_len}, 64'd200);
    i_link_ps = 2'd2; burst(200, 240);
    chk_pulses("u2_pulse", 24'h001000);
    i_link_ps = 2'd3; burst(200, 240);
    chk_pulses("u3_pulse", 24'h000100);
    i_link_ps = 2'd0; burst(200, 240);
    chk_pulses("u0_pulse", 24'h000001);

    // Complete WarmReset burst
    begin
      int rd0;
      rd0 = n_rd_rise;
      burst(12000, 12020);
      chk_pulses("wr_pulse", 24'h000010);
      check("wr_len", {39'd0, o_burst_len}, 64'd12000);
      check("wr_rd_rise", rd_rise_cyc - rise_cyc, 64'd2254);
      check("wr_rd_last", rd_last_cyc - rise_cyc, 64'd12003);
      check("wr_rd_count", n_rd_rise - rd0, 64'd1);
      check("wr_rd_low", {63'd0, o_reset_detect}, 64'd0);
    end

    // enable dropped mid-burst
    burst(60, 600);
    check("en_pre_run", {60'd0, o_poll_run}, 64'd1);
    @(posedge slow_clk); #1;
    drive_raw(1'b1);
    idle(4004);
    check("en_rd_before", {63'd0, o_reset_detect}, 64'd1);
    i_enable = 1'b0;
    idle(3);
    check("en_rd_after", {63'd0, o_reset_detect}, 64'd0);
    check("en_run_after", {60'd0, o_poll_run}, 64'd0);
    i_enable = 1'b1;
    idle(12000 - 4004 - 3);
    drive_raw(1'b0);
    idle(30);
    chk_pulses("en_pulse", 24'h000000);
    check("en_rd_end", {63'd0, o_reset_detect}, 64'd0);

    // reset_n asserted mid-burst
    burst(60, 600);
    check("rs_pre_run", {60'd0, o_poll_run}, 64'd1);
    @(posedge slow_clk); #1;
    drive_raw(1'b1);
    idle(4004);
    check("rs_rd_before", {63'd0, o_reset_detect}, 64'd1);
    reset_n = 1'b0;
    idle(3);
    check("rs_rd_after", {63'd0, o_reset_detect}, 64'd0);
    check("rs_run_after", {60'd0, o_poll_run}, 64'd0);
    check("rs_len_after", {39'd0, o_burst_len}, 64'd0);
    idle(12000 - 4004 - 3);
    drive_raw(1'b0);
    idle(10);
    reset_n = 1'b1;
    idle(30);
    chk_pulses("rs_pulse", 24'h000000);
    check("rs_active", {63'd0, o_lfps_active}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
